// File: rtl/serdes_pkg.sv
// Shared types for the serial bit source feeding the sequence detector.
// Holds the serialiser state encoding and the default idle line level.
package serdes_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } ser_state_t;

  localparam logic IDLE_LVL_DEF = 1'b0;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/serial_bit_source.sv
// Parallel-to-serial shifter with valid/ready input and idle gap insertion.
// Ports: clk, rst_n, din/din_valid/din_ready in; sout/sout_valid/busy/word_done out.
module serial_bit_source
  import serdes_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter int   GAP       = 0,
  parameter logic IDLE_LVL  = IDLE_LVL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST =
    (GAP > 0) ? GW'(GAP - 1) : '0;

  ser_state_t       state;
  ser_state_t       state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nx;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_cnt_nx;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_cnt_nx;
  logic             last_bit;
  logic             last_gap;
  logic             accept;
  logic             head_nx;

  assign last_bit = (bit_cnt == BIT_LAST);
  assign last_gap = (gap_cnt == GAP_LAST);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    din_ready  = 1'b0;
    accept     = 1'b0;
    head_nx    = 1'b0;

    case (state)
      S_IDLE:  din_ready = 1'b1;
      S_SHIFT: din_ready = last_bit && (GAP == 0);
      S_GAP:   din_ready = last_gap;
      default: din_ready = 1'b0;
    endcase

    accept = din_valid & din_ready;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx   = S_SHIFT;
          sreg_nx    = din;
          bit_cnt_nx = '0;
        end
      end
      S_SHIFT: begin
        if (!last_bit) begin
          bit_cnt_nx = bit_cnt + BW'(1);
          if (MSB_FIRST)
            sreg_nx = {sreg[WIDTH-2:0], 1'b0};
          else
            sreg_nx = {1'b0, sreg[WIDTH-1:1]};
        end else if (GAP > 0) begin
          state_nx   = S_GAP;
          gap_cnt_nx = '0;
        end else if (accept) begin
          sreg_nx    = din;
          bit_cnt_nx = '0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_GAP: begin
        if (!last_gap) begin
          gap_cnt_nx = gap_cnt + GW'(1);
        end else if (accept) begin
          state_nx   = S_SHIFT;
          sreg_nx    = din;
          bit_cnt_nx = '0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    head_nx = MSB_FIRST ? sreg_nx[WIDTH-1] : sreg_nx[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      sreg    <= sreg_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  // Outputs are registered from next-state so the bit on sout
  // always matches the state the shifter is entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout       <= IDLE_LVL;
      sout_valid <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      sout       <= (state_nx == S_SHIFT) ? head_nx : IDLE_LVL;
      sout_valid <= (state_nx == S_SHIFT);
      word_done  <= (state_nx == S_SHIFT) &&
                    (bit_cnt_nx == BIT_LAST);
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Randomised bench for serial_bit_source across three configurations.
// A timeline model predicts every output from accept times and parameters.
module tb_serial_bit_source;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din [3];
  logic       din_valid [3];
  logic       din_ready [3];
  logic       sout [3];
  logic       sout_valid [3];
  logic       busy [3];
  logic       word_done [3];

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] wq[$];

  always #5 clk = ~clk;

  serial_bit_source #(
    .WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LVL(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .sout(sout[0]),
    .sout_valid(sout_valid[0]), .busy(busy[0]),
    .word_done(word_done[0])
  );

  serial_bit_source #(
    .WIDTH(8), .MSB_FIRST(1'b1), .GAP(2), .IDLE_LVL(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .sout(sout[1]),
    .sout_valid(sout_valid[1]), .busy(busy[1]),
    .word_done(word_done[1])
  );

  serial_bit_source #(
    .WIDTH(8), .MSB_FIRST(1'b0), .GAP(1), .IDLE_LVL(1'b0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .din(din[2]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .sout(sout[2]),
    .sout_valid(sout_valid[2]), .busy(busy[2]),
    .word_done(word_done[2])
  );

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 1;
  endfunction

  function automatic bit msb_of(input int k);
    return (k != 2);
  endfunction

  function automatic logic idl_of(input int k);
    return (k == 1);
  endfunction

  // Word accepted at cycle a owns cycles a+1..a+8 for its bits,
  // then GAP idle cycles; the next accept can happen at a+8+GAP.
  task automatic run_stream(input int k, input int vpct,
                            input string name);
    int n, a, free, g, idx;
    bit hold, done;
    logic [7:0] cur, q[$];
    logic e_rdy, e_sv, e_s, e_done, e_busy;
    q = wq;
    g = gap_of(k);
    a = -1000;
    free = 0;
    hold = 0;
    done = 0;
    cur = '0;
    n = 0;
    while (!done && n < 3000) begin
      n++;
      @(posedge clk); #1;
      if (q.size() > 0 && !hold &&
          $urandom_range(99) < vpct)
        hold = 1;
      din_valid[k] = hold;
      din[k] = hold ? q[0] : 8'($urandom);
      @(negedge clk);
      e_rdy  = (n >= free);
      e_sv   = (n > a) && (n <= a + 8);
      idx    = n - a - 1;
      e_s    = idl_of(k);
      if (e_sv)
        e_s = msb_of(k) ? cur[7 - idx] : cur[idx];
      e_done = (n == a + 8);
      e_busy = (n > a) && (n <= a + 8 + g);
      vectors += 5;
      if (din_ready[k] !== e_rdy) begin
        miscompares++;
        $display("FAIL %s dut%0d n=%0d din_ready got %b want %b",
                 name, k, n, din_ready[k], e_rdy);
      end
      if (sout_valid[k] !== e_sv) begin
        miscompares++;
        $display("FAIL %s dut%0d n=%0d sout_valid got %b want %b",
                 name, k, n, sout_valid[k], e_sv);
      end
      if (sout[k] !== e_s) begin
        miscompares++;
        $display("FAIL %s dut%0d n=%0d sout got %b want %b",
                 name, k, n, sout[k], e_s);
      end
      if (word_done[k] !== e_done) begin
        miscompares++;
        $display("FAIL %s dut%0d n=%0d word_done got %b want %b",
                 name, k, n, word_done[k], e_done);
      end
      if (busy[k] !== e_busy) begin
        miscompares++;
        $display("FAIL %s dut%0d n=%0d busy got %b want %b",
                 name, k, n, busy[k], e_busy);
      end
      if (hold && e_rdy) begin
        a = n;
        cur = q.pop_front();
        free = n + 8 + g;
        hold = 0;
      end
      if (q.size() == 0 && !hold && n >= a + 8 + g + 2)
        done = 1;
    end
    din_valid[k] = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL %s dut%0d timeout got %0d cycles want done",
               name, k, n);
    end
  endtask

  task automatic check_idle(input string name);
    for (int k = 0; k < 3; k++) begin
      vectors += 4;
      if (sout[k] !== idl_of(k)) begin
        miscompares++;
        $display("FAIL %s dut%0d sout got %b want %b",
                 name, k, sout[k], idl_of(k));
      end
      if (sout_valid[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s dut%0d sout_valid got %b want 0",
                 name, k, sout_valid[k]);
      end
      if (busy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s dut%0d busy got %b want 0",
                 name, k, busy[k]);
      end
      if (word_done[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s dut%0d word_done got %b want 0",
                 name, k, word_done[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset");
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (din_ready[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_ready dut%0d got %b want 1",
                 k, din_ready[k]);
      end
    end
  endtask

  task automatic test_msb_word();
    wq = '{8'hB4};
    run_stream(0, 100, "msb_b4");
  endtask

  task automatic test_back_to_back();
    wq = '{8'hFF, 8'h00};
    run_stream(0, 100, "b2b_ff00");
  endtask

  task automatic test_gap();
    wq = '{8'($urandom), 8'($urandom), 8'hB4};
    run_stream(1, 100, "gap2");
  endtask

  task automatic test_lsb();
    wq = '{8'h01};
    run_stream(2, 100, "lsb_01");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      wq = {};
      for (int i = 0; i < 16; i++)
        wq.push_back(8'($urandom));
      run_stream(k, 50, "random");
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    din[0] = 8'hA5;
    din_valid[0] = 1'b1;
    @(negedge clk);
    vectors++;
    if (din_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_ready got %b want 1", din_ready[0]);
    end
    @(posedge clk); #1;
    din_valid[0] = 1'b0;
    din[0] = 8'($urandom);
    repeat (2) @(posedge clk);
    #2;
    vectors += 2;
    if (sout_valid[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_bit3_valid got %b want 1", sout_valid[0]);
    end
    if (sout[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_bit3 got %b want 1", sout[0]);
    end
    rst_n = 1'b0;
    #1;
    check_idle("rmid_async");
    repeat (3) begin
      @(negedge clk);
      check_idle("rmid_hold");
    end
    rst_n = 1'b1;
    wq = '{8'h5A};
    run_stream(0, 100, "rmid_5a");
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      din[k] = '0;
      din_valid[k] = 1'b0;
    end
    test_reset();
    test_msb_word();
    test_back_to_back();
    test_gap();
    test_lsb();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
